spi_dac_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 22 ++
 rtl/spi_dac_tx_clk_en_div.sv | 31 +++
 rtl/spi_dac_tx.sv | 129 ++++++++++++
 tb/tb_spi_dac_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio processor chain and its DAC output stage.
package audio_pkg;

  localparam int          FRAME_BITS       = 16;
  localparam logic [3:0]  DAC_CTRL_DEFAULT = 4'b0011;
  localparam logic [9:0]  ADC_OFFSET       = 10'd512;
  localparam logic [9:0]  DAC_OFFSET       = 10'd512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LATCH = 2'd3
  } dac_state_e;

  // Control nibble, 10-bit sample, two don't-care LSBs.
  function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [3:0] ctrl,
                                                      input logic [9:0] sample);
    return {ctrl, sample, 2'b00};
  endfunction

endpackage

// File: rtl/spi_dac_tx_clk_en_div.sv
// Clock-enable divider: one-cycle tick every CLK_DIV sysclk cycles, restarted by clear.
module clk_en_div #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  // Suppressed while held in clear so a CLK_DIV of 1 cannot tick from a stopped counter.
  assign tick   = w_last && !clear;

  always_ff @(posedge sysclk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_dac_tx.sv
// Serialises 10-bit DAC samples into 16-bit SPI write frames with CS, SCK, SDI and LDAC,
// buffering one pending sample so strobes arriving mid-frame are kept (newest wins).
module spi_dac_tx #(
  parameter int         CLK_DIV   = 25,
  parameter logic [3:0] CTRL_BITS = audio_pkg::DAC_CTRL_DEFAULT
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n,
  output logic       busy,
  output logic       overrun
);
  import audio_pkg::*;

  dac_state_e            r_state;
  logic [FRAME_BITS-2:0] r_shreg;
  logic [3:0]            r_bitcnt;
  logic                  r_pend;
  logic [9:0]            r_pend_data;
  logic                  r_cs_n, r_sck, r_sdi, r_ld_n, r_busy, r_overrun;

  logic                  w_tick;
  logic                  w_clear;
  logic                  w_start;
  logic [FRAME_BITS-1:0] w_word;

  assign w_clear = (r_state == IDLE);
  assign w_start = r_pend || data_valid;
  assign w_word  = dac_frame(CTRL_BITS, r_pend ? r_pend_data : data_in);

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .sysclk (sysclk),
    .rst    (rst),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_cs_n      <= 1'b1;
      r_sck       <= 1'b0;
      r_sdi       <= 1'b0;
      r_ld_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      // Anything arriving while a frame is in flight goes to the single pending slot.
      if (r_state != IDLE && data_valid) begin
        r_pend      <= 1'b1;
        r_pend_data <= data_in;
        r_overrun   <= r_pend;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= SHIFT;
            r_shreg  <= w_word[FRAME_BITS-2:0];
            r_sdi    <= w_word[FRAME_BITS-1];
            r_bitcnt <= 4'd15;
            r_busy   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_sck    <= 1'b0;
          end
          if (r_pend) begin
            r_pend <= data_valid;
            if (data_valid) r_pend_data <= data_in;
          end
        end

        SHIFT: begin
          if (w_tick) begin
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else if (r_bitcnt == 4'd0) begin
              r_sck   <= 1'b0;
              r_cs_n  <= 1'b1;
              r_sdi   <= 1'b0;
              r_state <= GAP;
            end else begin
              // Next bit goes out at the start of the low phase, stable across the rise.
              r_sck    <= 1'b0;
              r_bitcnt <= r_bitcnt - 4'd1;
              r_sdi    <= r_shreg[FRAME_BITS-2];
              r_shreg  <= {r_shreg[FRAME_BITS-3:0], 1'b0};
            end
          end
        end

        GAP: begin
          if (w_tick) begin
            r_ld_n  <= 1'b0;
            r_state <= LATCH;
          end
        end

        LATCH: begin
          if (w_tick) begin
            r_ld_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign dac_cs_n = r_cs_n;
  assign dac_sck  = r_sck;
  assign dac_sdi  = r_sdi;
  assign dac_ld_n = r_ld_n;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_dac_tx.sv
// Randomised bench for spi_dac_tx: a timing-level model predicts frames, busy and overrun;
// a monitor decodes the SPI bus and checks against the scoreboard queue.
module tb_spi_dac_tx;
  localparam int D    = 2;
  localparam int BUSY = 34 * D;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, overrun;

  spi_dac_tx #(.CLK_DIV(D), .CTRL_BITS(4'b0011)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .dac_cs_n   (dac_cs_n),
    .dac_sck    (dac_sck),
    .dac_sdi    (dac_sdi),
    .dac_ld_n   (dac_ld_n),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  // Reference model state: prediction for the outputs after the next edge.
  logic [15:0] exp_q[$];
  bit          m_busy = 0, m_pend = 0, m_ovr = 0;
  int          m_rem = 0;
  logic [9:0]  m_pd = '0;
  int          phase = 0;   // 1: quiet-idle window, 2: stimulus finished
  int          n_chk = 0, n_pass = 0;

  function automatic logic [15:0] frame_of(input logic [9:0] s);
    return {4'b0011, s, 2'b00};
  endfunction

  task automatic model_start(input logic [9:0] s);
    exp_q.push_back(frame_of(s));
    m_busy = 1;
    m_rem  = BUSY;
  endtask

  // Present inputs for the coming edge and advance the model by that edge.
  task automatic step(input bit v, input logic [9:0] d);
    @(negedge sysclk);
    rst = 0; data_valid = v; data_in = d;
    m_ovr = 0;
    if (!m_busy) begin
      if (m_pend) begin
        model_start(m_pd);
        m_pend = v;
        if (v) m_pd = d;
      end else if (v) begin
        model_start(d);
      end
    end else begin
      if (v) begin
        m_ovr  = m_pend;
        m_pend = 1;
        m_pd   = d;
      end
      m_rem--;
      if (m_rem == 0) m_busy = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0);
  endtask

  task automatic reset_cyc();
    @(negedge sysclk);
    rst = 1; data_valid = 0;
    m_busy = 0; m_pend = 0; m_ovr = 0; m_rem = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Stimulus
  initial begin
    repeat (3) reset_cyc();
    phase = 1;
    idle(100);
    phase = 0;
    step(1, 10'h2AA); idle(100);
    step(1, 10'h000); idle(2000);
    step(1, 10'h3FF); idle(100);
    step(1, 10'h111); idle(9); step(1, 10'h222); idle(160);
    step(1, 10'h111); idle(4); step(1, 10'h222); idle(4); step(1, 10'h333); idle(160);
    step(1, 10'h2AA); idle(9); step(1, 10'h0F0); idle(19);
    reset_cyc();
    idle(100);
    step(1, 10'h155); idle(100);
    for (int i = 0; i < 300; i++) begin
      step(1, 10'($urandom_range(0, 1023)));
      idle($urandom_range(0, 90));
    end
    idle(200);
    phase = 2;
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_sck = 0, in_frame = 0, ld_cs_bad = 0;
    int          nb = 0, brun = 0, lrun = 0, idle_viol = 0, sck_out = 0;
    logic [15:0] sh = '0;
    forever begin
      @(posedge sysclk); #1;
      if (phase == 2) break;
      if (rst) begin
        chk("reset_state", {26'd0, dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, overrun},
            {26'd0, 6'b100100});
        if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
        in_frame = 0; nb = 0; brun = 0; lrun = 0; ld_cs_bad = 0;
      end else begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        if (overrun || m_ovr) chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (phase == 1 && (!dac_cs_n || dac_sck || !dac_ld_n || busy || dac_sdi)) idle_viol++;
        if (dac_cs_n && dac_sck) sck_out++;
        if (!dac_cs_n) begin
          in_frame = 1;
          if (dac_sck && !prev_sck) begin
            sh = {sh[14:0], dac_sdi};
            nb++;
          end
        end else if (in_frame) begin
          in_frame = 0;
          chk("sck_rises", nb, 16);
          if (exp_q.size() == 0) chk("unexpected_frame", {16'd0, sh}, 32'hFFFF_FFFF);
          else chk("frame", {16'd0, sh}, {16'd0, exp_q.pop_front()});
          nb = 0;
        end
        if (busy) brun++;
        else if (brun > 0) begin
          chk("busy_len", brun, BUSY);
          brun = 0;
        end
        if (!dac_ld_n) begin
          lrun++;
          if (!dac_cs_n) ld_cs_bad = 1;
        end else if (lrun > 0) begin
          chk("ld_len", lrun, D);
          chk("ld_cs_high", {31'd0, ld_cs_bad}, 32'd0);
          lrun = 0; ld_cs_bad = 0;
        end
      end
      prev_sck = dac_sck;
    end
    chk("idle_quiet", idle_viol, 0);
    chk("sck_outside_frame", sck_out, 0);
    chk("frames_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
